// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage.
//
// Contents:
//   XLEN          - PC / instruction-address width.
//   PC_RESET      - default PC loaded on reset.
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0), returned with a misaligned-fetch exception.
//   fetch_state_t - fetch FSM state encoding.
//   fetch_data_t  - bundle handed from fetch to decode.
//   pc_incr()     - sequential next-PC, modulo 2^XLEN.
package fetch_stage_pkg;

  localparam int unsigned XLEN      = 64;
  localparam logic [63:0] PC_RESET  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq,   // presenting a request to the instruction bus
    StWait,  // address accepted, waiting for read data
    StOut    // holding a bundle for decode
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     raw_instr;
  } fetch_data_t;

  // Plain truncating add: the top word address wraps to zero.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Front-end fetch stage. Owns the PC, issues one instruction-bus request at a time and hands
// each returned word to decode as a valid/pc/instr bundle. Redirects from later stages
// override everything; a response belonging to a request issued before a redirect is dropped.
//
// Optional feature (macro FETCH_MISALIGN_EN): a request address with bits [1:0] != 0 is not
// issued; instead a bundle with out_exc_o=1 and a NOP instruction is produced. With the macro
// undefined out_exc_o is tied low and every address is issued unchecked.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   ireq_valid_o/addr_o  instruction-bus request
//   iresp_addr_ok_i      bus accepted the presented address this cycle
//   iresp_data_ok_i      read data valid this cycle (iresp_data_i)
//   out_valid_o/pc_o/instr_o/exc_o  bundle to decode, held while out_ready_i is low
//   out_ready_i          decode takes the bundle this cycle
//   redirect_valid_i/pc_i  single-cycle redirect pulse and target
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] PcReset = PC_RESET
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  output logic            ireq_valid_o,
  output logic [XLEN-1:0] ireq_addr_o,
  input  logic            iresp_addr_ok_i,
  input  logic            iresp_data_ok_i,
  input  logic [31:0]     iresp_data_i,

  output logic            out_valid_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     out_instr_o,
  output logic            out_exc_o,
  input  logic            out_ready_i,

  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  // Address presented on the bus. Differs from pc_q only while a killed request is still
  // waiting for address acceptance and must be held stable.
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  // Set when the outstanding (or still-presented) request is wrong-path; its response is dropped.
  logic            kill_q, kill_d;
  fetch_data_t     out_q, out_d;

  logic            out_load;  // capture a new bundle this cycle
  logic            out_clr;   // bundle consumed or flushed
  logic            misalign;  // current request address must not go to the bus

`ifdef FETCH_MISALIGN_EN
  // While kill_q is set the presented address is an older, already-checked one.
  assign misalign = (req_addr_q[1:0] != 2'b00) && !kill_q;
`else
  assign misalign = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    out_load   = 1'b0;
    out_clr    = 1'b0;

    unique case (state_q)
      StReq: begin
        if (misalign) begin
          // Nothing on the bus, so a redirect simply retargets with no kill.
          if (redirect_valid_i) begin
            pc_d       = redirect_pc_i;
            req_addr_d = redirect_pc_i;
          end else begin
            out_load = 1'b1;
            state_d  = StOut;
          end
        end else if (iresp_addr_ok_i) begin
          if (iresp_data_ok_i) begin
            if (redirect_valid_i) begin
              // Zero-latency response on the wrong path: drop it and restart at the target.
              pc_d       = redirect_pc_i;
              req_addr_d = redirect_pc_i;
              kill_d     = 1'b0;
            end else if (kill_q) begin
              req_addr_d = pc_q;
              kill_d     = 1'b0;
            end else begin
              out_load = 1'b1;
              state_d  = StOut;
            end
          end else begin
            state_d = StWait;
            if (redirect_valid_i) begin
              kill_d     = 1'b1;
              pc_d       = redirect_pc_i;
              req_addr_d = redirect_pc_i;
            end
          end
        end else if (redirect_valid_i) begin
          // Request not yet accepted: the bus address must stay put, so only pc moves.
          kill_d = 1'b1;
          pc_d   = redirect_pc_i;
        end
      end

      StWait: begin
        if (iresp_data_ok_i) begin
          if (redirect_valid_i) begin
            pc_d       = redirect_pc_i;
            req_addr_d = redirect_pc_i;
            kill_d     = 1'b0;
            state_d    = StReq;
          end else if (kill_q) begin
            req_addr_d = pc_q;
            kill_d     = 1'b0;
            state_d    = StReq;
          end else begin
            out_load = 1'b1;
            state_d  = StOut;
          end
        end else if (redirect_valid_i) begin
          // A repeated redirect only retargets; still exactly one response to drop.
          kill_d     = 1'b1;
          pc_d       = redirect_pc_i;
          req_addr_d = redirect_pc_i;
        end
      end

      StOut: begin
        if (redirect_valid_i) begin
          // Decode is flushed by the same redirect, so a coincident out_ready is ignored.
          out_clr    = 1'b1;
          pc_d       = redirect_pc_i;
          req_addr_d = redirect_pc_i;
          state_d    = StReq;
        end else if (out_ready_i) begin
          out_clr    = 1'b1;
          pc_d       = pc_incr(pc_q);
          req_addr_d = pc_incr(pc_q);
          state_d    = StReq;
        end
      end

      default: begin
        state_d = StReq;
      end
    endcase
  end

  // Output bundle: loaded on capture, valid dropped on accept/flush, payload otherwise held.
  always_comb begin
    out_d = out_q;
    if (out_load) begin
      out_d.valid     = 1'b1;
      out_d.pc        = req_addr_q;
      out_d.raw_instr = misalign ? NOP_INSTR : iresp_data_i;
    end else if (out_clr) begin
      out_d.valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StReq;
      pc_q       <= PcReset;
      req_addr_q <= PcReset;
      kill_q     <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      out_q      <= out_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic exc_q, exc_d;

  always_comb begin
    exc_d = exc_q;
    if (out_load) begin
      exc_d = misalign;
    end else if (out_clr) begin
      exc_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end

  assign out_exc_o = exc_q;
`else
  assign out_exc_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  // Gated by reset so no request is presented while the stage is held in reset.
  assign ireq_valid_o = rst_ni && (state_q == StReq) && !misalign;
  assign ireq_addr_o  = req_addr_q;

  assign out_valid_o = out_q.valid;
  assign out_pc_o    = out_q.pc;
  assign out_instr_o = out_q.raw_instr;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end pipeline stage: owns the PC and issues instruction-bus requests.
- Returns one 32-bit instruction per handshake to the decode stage as a valid/pc/raw_instr bundle (fetch_data_t fields).
- Accepts redirects (branch/jump/flush) from later stages and discards wrong-path data.
- At most one bus transaction in flight; no prediction.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC value loaded at reset.
- XLEN, 64, PC/address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset. Asynchronous assert, active-low.
- ireq_valid  out  1  instruction-bus request valid.
- ireq_addr  out  XLEN  request address.
- iresp_addr_ok  in  1  bus accepted the address this cycle.
- iresp_data_ok  in  1  read data valid this cycle.
- iresp_data  in  32  instruction word.
- out_valid  out  1  fetch_data_t.valid to decode.
- out_pc  out  XLEN  fetch_data_t.pc.
- out_instr  out  32  fetch_data_t.raw_instr.
- out_exc  out  1  instruction-address-misaligned flag (optional feature only).
- out_ready  in  1  decode accepts the bundle this cycle.
- redirect_valid  in  1  single-cycle redirect pulse.
- redirect_pc  in  XLEN  redirect target.

Behaviour:
- Reset values:
  - pc=PC_RESET, state=S_REQ, kill=0.
  - out_valid=0, out_pc=0, out_instr=0, out_exc=0.
  - ireq_valid=0 during reset; ireq_addr=req_addr=PC_RESET.
- Mid-operation reset: everything returns to reset values immediately. A bus response arriving after reset release with no request issued is ignored (state is S_REQ and req not yet accepted).
- States:
  - S_REQ: ireq_valid=1, ireq_addr=req_addr.
    - addr_ok=1, data_ok=0 -> S_WAIT.
    - addr_ok=1, data_ok=1 -> capture, go to S_OUT.
  - S_WAIT: ireq_valid=0.
    - data_ok=1 -> capture, go to S_OUT.
  - S_OUT: out_valid=1, bundle held stable.
    - out_ready=1 -> pc<=pc+4, req_addr<=pc+4, out_valid<=0, go to S_REQ.
- Capture writes out_pc=req_addr and out_instr=iresp_data. out_valid rises the next cycle.
- Minimum latency, request to out_valid: 1 cycle after a same-cycle addr_ok+data_ok.
- Accept-to-next-request: 1 cycle, no back-to-back overlap.
- Bus rule: ireq_addr stays stable while ireq_valid=1 and addr_ok=0, even across a redirect.
- PC arithmetic: pc+4 modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Redirect (priority over all other events):
  - In S_OUT: out_valid<=0; pc and req_addr <= redirect_pc; go to S_REQ. A same-cycle out_ready is ignored; decode is flushed by the same redirect.
  - In S_WAIT, or in S_REQ with addr_ok=1 and data_ok=0: kill<=1; pc and req_addr <= redirect_pc. The response, when it arrives, is dropped (no capture), kill<=0, go to S_REQ.
  - In S_REQ with addr_ok=0: kill<=1; pc<=redirect_pc; req_addr is held until addr_ok (old address). Then behave as above; req_addr<=pc on the drop.
  - In S_REQ or S_WAIT coinciding with data_ok: the data is dropped; go directly to S_REQ at redirect_pc.
  - Second redirect while kill=1: pc updates to the newest target; still exactly one response is dropped.

Optional Feature:
- FETCH_MISALIGN_EN defined:
  - In S_REQ with req_addr[1:0]!=0, no bus request is issued.
  - Next cycle: S_OUT with out_exc=1, out_instr=32'h0000_0013 (NOP), out_pc=req_addr.
  - Redirect handling is unchanged.
- Undefined: out_exc tied to 0; the address is issued unchecked.

Decomposition:
- common package: PC_RESET default constant, NOP_INSTR (32'h13).
- pipes package: fetch_state_t enum {S_REQ, S_WAIT, S_OUT}; fetch_data_t packing.
- No sub-module; PC/next-PC logic is inline.

Test Plan:
- Reset release, bus with addr_ok=data_ok=1 every cycle, out_ready=1 -> out_pc = 8000_0000, 8000_0004, 8000_0008 on successive accepts, one bundle every 2 cycles.
- data_ok 3 cycles after addr_ok, out_ready held 0 for 4 cycles -> out_valid stays 1; out_pc and out_instr stable; no new ireq_valid until the accept.
- Redirect to 8000_1000 while in S_WAIT -> returning instr dropped, out_valid stays 0; next request addr = 8000_1000.
- Redirect while ireq_valid=1, addr_ok=0 -> ireq_addr unchanged until addr_ok; response dropped; following request = redirect target.
- redirect_valid and out_ready both 1 in S_OUT -> out_valid 0 next cycle, pc = redirect_pc, no pc+4.
- With FETCH_MISALIGN_EN, redirect to 8000_0002 -> no ireq_valid; out_valid=1, out_exc=1, out_instr=0000_0013, out_pc=8000_0002.
